// File: rtl/multiplication_modulo_pkg.sv
// Shared types and constants for the bit-serial modular multiplier.
package multiplication_modulo_pkg;

  localparam int DEFAULT_SIZE = 64;
  localparam int CNT_W        = $clog2(DEFAULT_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_MULT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mod_double_add.sv
// One interleaved step: u = (2r mod n + x) mod n, 0 when n == 0.
// Combinational, no backpressure; needs r < n and x < n (or x in {0,1}).
module mod_double_add
  import multiplication_modulo_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic [SIZE-1:0] r,
  input  logic [SIZE-1:0] x,
  input  logic [SIZE-1:0] n,
  output logic [SIZE-1:0] u
);

  logic [SIZE:0] n_ext;
  logic [SIZE:0] dbl;
  logic [SIZE:0] sum;

  assign n_ext = {1'b0, n};

  // One extra bit keeps 2r and t + x from wrapping before the compare.
  always_comb begin
    dbl = {r, 1'b0};
    if (dbl >= n_ext) begin
      dbl = dbl - n_ext;
    end
    sum = dbl + {1'b0, x};
    if (sum >= n_ext) begin
      sum = sum - n_ext;
    end
    u = (n == '0) ? '0 : sum[SIZE-1:0];
  end

endmodule

// File: rtl/multiplication_modulo.sv
// (A * B) mod N by reducing B MSB-first, then interleaved MULT over A; result valid 2*SIZE edges after last capture.
// Inputs ready only in IDLE until captured; result held in DONE until output_tready.
module multiplication_modulo
  import multiplication_modulo_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_multiplier_tdata,
  input  logic            input_multiplier_tvalid,
  output logic            input_multiplier_tready,
  input  logic [SIZE-1:0] input_multiplicand_tdata,
  input  logic            input_multiplicand_tvalid,
  output logic            input_multiplicand_tready,
  input  logic [SIZE-1:0] input_modulus_tdata,
  input  logic            input_modulus_tvalid,
  output logic            input_modulus_tready,
  output logic [SIZE-1:0] output_tdata,
  output logic            output_tvalid,
  input  logic            output_tready
);

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] CNT_TOP = CW'(SIZE - 1);

  state_e          state_q, state_d;
  logic [SIZE-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
  logic            a_cap_q, a_cap_d, b_cap_q, b_cap_d, n_cap_q, n_cap_d;
  logic [SIZE-1:0] r_q, r_d, bp_q, bp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_vld_q, out_vld_d;

  logic            idle;
  logic            a_take, b_take, n_take;
  logic [SIZE-1:0] step_x;
  logic [SIZE-1:0] step_u;

  assign idle   = (state_q == ST_IDLE);
  assign input_multiplier_tready   = idle & ~a_cap_q;
  assign input_multiplicand_tready = idle & ~b_cap_q;
  assign input_modulus_tready      = idle & ~n_cap_q;
  assign a_take = input_multiplier_tready   & input_multiplier_tvalid;
  assign b_take = input_multiplicand_tready & input_multiplicand_tvalid;
  assign n_take = input_modulus_tready      & input_modulus_tvalid;

  assign output_tdata  = r_q;
  assign output_tvalid = out_vld_q;

  // REDUCE feeds single bits of B; MULT feeds the reduced B' gated by a bit of A.
  assign step_x = (state_q == ST_REDUCE) ? {{(SIZE-1){1'b0}}, b_q[cnt_q]}
                                         : (a_q[cnt_q] ? bp_q : '0);

  mod_double_add #(.SIZE(SIZE)) u_step (
    .r (r_q),
    .x (step_x),
    .n (n_q),
    .u (step_u)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    n_d       = n_q;
    a_cap_d   = a_cap_q;
    b_cap_d   = b_cap_q;
    n_cap_d   = n_cap_q;
    r_d       = r_q;
    bp_d      = bp_q;
    cnt_d     = cnt_q;
    out_vld_d = out_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (a_take) begin
          a_d     = input_multiplier_tdata;
          a_cap_d = 1'b1;
        end
        if (b_take) begin
          b_d     = input_multiplicand_tdata;
          b_cap_d = 1'b1;
        end
        if (n_take) begin
          n_d     = input_modulus_tdata;
          n_cap_d = 1'b1;
        end
        if (a_cap_d && b_cap_d && n_cap_d) begin
          state_d = ST_REDUCE;
          r_d     = '0;
          cnt_d   = CNT_TOP;
        end
      end
      ST_REDUCE: begin
        r_d   = step_u;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          bp_d    = step_u;
          r_d     = '0;
          cnt_d   = CNT_TOP;
          state_d = ST_MULT;
        end
      end
      ST_MULT: begin
        r_d   = step_u;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d   = ST_DONE;
          out_vld_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (output_tready) begin
          out_vld_d = 1'b0;
          a_cap_d   = 1'b0;
          b_cap_d   = 1'b0;
          n_cap_d   = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      n_q       <= '0;
      a_cap_q   <= 1'b0;
      b_cap_q   <= 1'b0;
      n_cap_q   <= 1'b0;
      r_q       <= '0;
      bp_q      <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      n_q       <= n_d;
      a_cap_q   <= a_cap_d;
      b_cap_q   <= b_cap_d;
      n_cap_q   <= n_cap_d;
      r_q       <= r_d;
      bp_q      <= bp_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_multiplication_modulo.sv
// Directed bench for multiplication_modulo with SIZE=64 and hand-computed results.
module tb_multiplication_modulo;

  localparam int SIZE = 64;
  localparam int LAT  = 2 * SIZE;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SIZE-1:0] a_dat, b_dat, n_dat;
  logic            a_vld, b_vld, n_vld;
  logic            a_rdy, b_rdy, n_rdy;
  logic [SIZE-1:0] out_dat;
  logic            out_vld;
  logic            out_rdy;

  int checks = 0;
  int errors = 0;
  int lat;

  multiplication_modulo #(.SIZE(SIZE)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .input_multiplier_tdata    (a_dat),
    .input_multiplier_tvalid   (a_vld),
    .input_multiplier_tready   (a_rdy),
    .input_multiplicand_tdata  (b_dat),
    .input_multiplicand_tvalid (b_vld),
    .input_multiplicand_tready (b_rdy),
    .input_modulus_tdata       (n_dat),
    .input_modulus_tvalid      (n_vld),
    .input_modulus_tready      (n_rdy),
    .output_tdata              (out_dat),
    .output_tvalid             (out_vld),
    .output_tready             (out_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts rising edges until output_tvalid is seen, bounded.
  task automatic wait_out(output int n_edges);
    n_edges = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      n_edges++;
      if (out_vld) break;
    end
  endtask

  task automatic send_all(input logic [63:0] a, input logic [63:0] b, input logic [63:0] n);
    a_dat = a; b_dat = b; n_dat = n;
    a_vld = 1'b1; b_vld = 1'b1; n_vld = 1'b1;
    @(posedge clk);
    #1;
    a_vld = 1'b0; b_vld = 1'b0; n_vld = 1'b0;
  endtask

  task automatic finish_out(input string tag);
    check({tag, "_busy_rdy"}, {61'd0, a_rdy, b_rdy, n_rdy}, 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_vld_drop"}, {63'd0, out_vld}, 64'd0);
    check({tag, "_rdy_back"}, {61'd0, a_rdy, b_rdy, n_rdy}, 64'd7);
  endtask

  task automatic run_all(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] n, input logic [63:0] exp);
    int l;
    send_all(a, b, n);
    wait_out(l);
    check({tag, "_lat"}, 64'(l), 64'(LAT));
    check({tag, "_res"}, out_dat, exp);
    finish_out(tag);
  endtask

  initial begin
    a_dat = '0; b_dat = '0; n_dat = '0;
    a_vld = 1'b0; b_vld = 1'b0; n_vld = 1'b0;
    out_rdy = 1'b1;
    #2 rst = 1'b0;
    #10;
    check("rst_tvalid", {63'd0, out_vld}, 64'd0);
    check("rst_tdata", out_dat, 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tready", {61'd0, a_rdy, b_rdy, n_rdy}, 64'd7);

    run_all("big", 64'd143563561627, 64'd21376213, 64'd69814, 64'd25103);
    run_all("small", 64'd7, 64'd5, 64'd11, 64'd2);

    // Modulus arrives later; A/B keep offering other data that must be ignored.
    a_dat = 64'd7; b_dat = 64'd5; a_vld = 1'b1; b_vld = 1'b1;
    @(posedge clk);
    #1;
    check("late_rdy_after_ab", {61'd0, a_rdy, b_rdy, n_rdy}, 64'd1);
    a_dat = 64'd99; b_dat = 64'd99;
    repeat (9) @(posedge clk);
    #1;
    n_dat = 64'd11; n_vld = 1'b1;
    @(posedge clk);
    #1;
    a_vld = 1'b0; b_vld = 1'b0; n_vld = 1'b0;
    wait_out(lat);
    check("late_lat", 64'(lat), 64'(LAT));
    check("late_res", out_dat, 64'd2);
    finish_out("late");

    run_all("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    run_all("wide", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4);
    run_all("n_zero", 64'd7, 64'd5, 64'd0, 64'd0);
    run_all("n_one", 64'd7, 64'd5, 64'd1, 64'd0);
    run_all("a_zero", 64'd0, 64'd5, 64'd11, 64'd0);

    // Output backpressure: 12*13 mod 100 = 56 held for 20 cycles.
    out_rdy = 1'b0;
    send_all(64'd12, 64'd13, 64'd100);
    wait_out(lat);
    check("bp_lat", 64'(lat), 64'(LAT));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_vld_hold", {63'd0, out_vld}, 64'd1);
      check("bp_dat_hold", out_dat, 64'd56);
      check("bp_in_rdy", {61'd0, a_rdy, b_rdy, n_rdy}, 64'd0);
    end
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_vld", {63'd0, out_vld}, 64'd0);
    check("bp_release_rdy", {61'd0, a_rdy, b_rdy, n_rdy}, 64'd7);
    @(posedge clk);
    #1;
    check("bp_single_xfer", {63'd0, out_vld}, 64'd0);

    // Reset in the middle of MULT, then a fresh transaction.
    send_all(64'd143563561627, 64'd21376213, 64'd69814);
    repeat (80) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_vld", {63'd0, out_vld}, 64'd0);
    check("mid_rst_dat", out_dat, 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_rdy", {61'd0, a_rdy, b_rdy, n_rdy}, 64'd7);
    run_all("after_rst", 64'd7, 64'd5, 64'd11, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplication_modulo.md
# multiplication_modulo

Computes `(multiplier × multiplicand) mod modulus` for unsigned SIZE-bit operands, using a bit-serial interleaved modular multiplier. It sits in the ElGamal datapath as the modular-multiply primitive; modular exponentiation and encryption stages build on it. Each of the three operands arrives on its own valid/ready channel, and the result leaves on one valid/ready output channel.

## Interface
- `SIZE`, default 64: operand and result width in bits.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `input_multiplier_tdata`  in  SIZE  multiplier A (unsigned, any value).
- `input_multiplier_tvalid`  in  1  A valid.
- `input_multiplier_tready`  out  1  A accepted when valid&ready.
- `input_multiplicand_tdata`  in  SIZE  multiplicand B (unsigned, any value).
- `input_multiplicand_tvalid` / `input_multiplicand_tready`: in 1 / out 1, B handshake.
- `input_modulus_tdata`  in  SIZE  modulus N.
- `input_modulus_tvalid` / `input_modulus_tready`: in 1 / out 1, N handshake.
- `output_tdata`  out  SIZE  result, in 0..N-1.
- `output_tvalid`  out  1  result valid.
- `output_tready`  in  1  downstream accepts result.

## Operation
- States: IDLE, REDUCE, MULT, DONE.
- IDLE:
  - Each input channel has its own holding register and "captured" flag.
  - A channel's tready = IDLE and not yet captured. A transfer on valid&ready latches the data and sets the flag.
  - Channels may arrive in any order or on the same edge.
  - On the edge where all three flags become set, go to REDUCE with R=0 and bit index = SIZE-1.
- REDUCE computes B' = B mod N, processing B MSB-first, one bit per cycle: R = step(R, addend = current bit of B).
  - After SIZE cycles, B' = R. Then R=0 and go to MULT.
- MULT processes A MSB-first, one bit per cycle: R = step(R, addend = A bit ? B' : 0).
  - After SIZE cycles, the result is R. Then go to DONE.
- step(r, x), with r<N and x≤N-1 (or x∈{0,1}):
  - t = 2r; if t≥N then t -= N.
  - u = t + x; if u≥N then u -= N.
  - All intermediates are SIZE+1 bits wide, so no overflow is possible.
- DONE:
  - `output_tvalid`=1 and `output_tdata`=R, both held stable until output_tready=1.
  - On that handshake edge: clear the captured flags, drop tvalid, return to IDLE.
- N=0: result is 0, with normal latency (the step output is forced to 0). N=1: the result is 0 naturally.
- Input tready stays 0 outside IDLE. Data offered during REDUCE/MULT/DONE is not taken.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, all flags cleared, R=0, `output_tdata`=0, `output_tvalid`=0, all input tready=1 once rst is high.
- Reset mid-operation aborts immediately. Any partial captures and results are discarded.
- Latency: `output_tvalid` is seen high after exactly 2·SIZE rising edges following the edge that captured the last operand (128 for SIZE=64).
- The capture edge and the first REDUCE edge are distinct cycles.
- Back-to-back operation: tready reasserts in the cycle after the output handshake.
- The output handshake edge and new operand captures never coincide, because inputs are not ready in DONE.
- Throughput: one result per 2·SIZE+2 cycles minimum.

## Structure
- Shared package:
  - state enum (IDLE/REDUCE/MULT/DONE);
  - default width constant (64);
  - counter width = $clog2(SIZE).
- Sub-module `mod_double_add` (combinational): inputs r, x, n (SIZE bits); output u, implementing step(). Includes the N=0 force-to-zero. Reused in both REDUCE and MULT.
- Top level: channel registers/flags, FSM, bit counter, and the R/B' registers.

## Test plan
- A=143563561627, B=21376213, N=69814, all valid together, output_tready=1 -> 25103 with tvalid after 128 edges (B'=13129).
- A=7, B=5, N=11 -> 2. Repeat with the modulus arriving 10 cycles after A and B: result is unchanged, and latency counts from the modulus capture.
- A=2^64-1, B=2^64-1, N=2^64-1 -> 0. A=2^64-1, B=2, N=2^64-3 -> 4 (checks the SIZE+1 width).
- N=0 -> 0. N=1 -> 0. A=0 -> 0.
- Hold output_tready=0 for 20 cycles in DONE: tvalid and tdata stay stable and input tready stays 0. Releasing it gives one transfer and a return to IDLE.
- Assert rst during MULT: all outputs reset, tvalid=0. A fresh transaction afterwards gives the correct result.
